// File: rtl/prf_pkg.sv
// Shared types for the reference-counted physical register file.
// Lifecycle states and sticky error flag bit positions.
package prf_pkg;

   typedef enum logic [1:0] {
      PR_FREE    = 2'd0,
      PR_PENDING = 2'd1,
      PR_VALID   = 2'd2
   } pr_life_e;

   localparam int ERR_COLL = 0;
   localparam int ERR_ILL  = 1;
   localparam int ERR_UF   = 2;
   localparam int ERR_OF   = 3;

endpackage

// File: rtl/prf_alloc_picker.sv
// Picks the K lowest set bits of a free vector, never bit 0.
// Slot k holds the k-th lowest candidate when o_vld[k] is set.
module prf_alloc_picker
   import prf_pkg::*;
#(
   parameter int N = 64,
   parameter int K = 2,
   parameter int W = 6
) (
   input  logic [N-1:0]        i_free,
   output logic [K-1:0]        o_vld,
   output logic [K-1:0][W-1:0] o_idx
);

   logic [N-1:0] w_cand;

   assign w_cand = i_free & ~N'(1);

   always_comb begin
      int n;
      n     = 0;
      o_vld = '0;
      o_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (w_cand[i]) begin
            for (int k = 0; k < K; k++) begin
               if (n == k) begin
                  o_vld[k] = 1'b1;
                  o_idx[k] = W'(i);
               end
            end
            n = n + 1;
         end
      end
   end

endmodule

// File: rtl/phy_regfile_rc.sv
// Physical register file with FREE/PENDING/VALID lifecycle and ref counts.
// Grants come from registered state, so a freed PR is grantable next cycle.
module phy_regfile_rc
   import prf_pkg::*;
#(
   parameter int NUM_PHY_REGS = 64,
   parameter int NUM_ARCH     = 32,
   parameter int NUM_CH       = 2,
   parameter int NUM_RD       = 2,
   parameter int DATA_W       = 32,
   parameter int RC_W         = 4,
   parameter int BYPASS       = 1,
   localparam int PW          = $clog2(NUM_PHY_REGS)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_CH-1:0]                      alloc_req,
   output logic [NUM_CH-1:0]                      alloc_gnt,
   output logic [NUM_CH-1:0][PW-1:0]              alloc_pr,
   input  logic [NUM_CH-1:0][NUM_RD-1:0][PW-1:0]  rd_addr,
   output logic [NUM_CH-1:0][NUM_RD-1:0][DATA_W-1:0] rd_data,
   output logic [NUM_CH-1:0][NUM_RD-1:0]          rd_valid,
   input  logic [NUM_CH-1:0]                      wr_en,
   input  logic [NUM_CH-1:0][PW-1:0]              wr_addr,
   input  logic [NUM_CH-1:0][DATA_W-1:0]          wr_data,
   input  logic [NUM_CH-1:0]                      inc_en,
   input  logic [NUM_CH-1:0][PW-1:0]              inc_pr,
   input  logic [NUM_CH-1:0]                      rel_en,
   input  logic [NUM_CH-1:0][PW-1:0]              rel_pr,
   output logic [PW:0]                            free_count,
   output logic [3:0]                             err_flags
);

   localparam int NP = NUM_PHY_REGS;
   localparam int CW = RC_W + $clog2(NUM_CH + 1) + 1;
   localparam int FW = PW + 1;
   localparam logic [RC_W-1:0] RC_MAX = '1;

   pr_life_e                  r_st   [NP];
   logic [RC_W-1:0]           r_cnt  [NP];
   logic [DATA_W-1:0]         r_data [NP];
   logic [FW-1:0]             r_free;
   logic [3:0]                r_err;

   pr_life_e                  w_st_nx   [NP];
   logic [RC_W-1:0]           w_cnt_nx  [NP];
   logic [DATA_W-1:0]         w_data_nx [NP];
   logic [FW-1:0]             w_free_nx;
   logic [NP-1:0]             w_free;
   logic [NUM_CH-1:0]         w_pk_vld;
   logic [NUM_CH-1:0][PW-1:0] w_pk_idx;
   logic [NUM_CH-1:0]         w_gnt;
   logic [NUM_CH-1:0][PW-1:0] w_gnt_pr;
   logic [NUM_CH-1:0]         w_wr_ok;
   logic [NUM_CH-1:0]         w_ill;
   logic [NUM_CH-1:0]         w_coll;
   logic                      w_of;
   logic                      w_uf;
   logic [3:0]                w_err_set;

   always_comb begin
      for (int i = 0; i < NP; i++)
         w_free[i] = (r_st[i] == PR_FREE);
   end

   prf_alloc_picker #(
      .N (NP),
      .K (NUM_CH),
      .W (PW)
   ) u_picker (
      .i_free (w_free),
      .o_vld  (w_pk_vld),
      .o_idx  (w_pk_idx)
   );

   // Requesting channels take picks in ascending channel order.
   always_comb begin
      int n;
      n        = 0;
      w_gnt    = '0;
      w_gnt_pr = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (alloc_req[c]) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (n == k && w_pk_vld[k]) begin
                  w_gnt[c]    = 1'b1;
                  w_gnt_pr[c] = w_pk_idx[k];
               end
            end
            n = n + 1;
         end
      end
   end

   assign alloc_gnt = w_gnt & {NUM_CH{rst_n}};
   assign alloc_pr  = w_gnt_pr;

   always_comb begin
      logic dup;
      logic live;
      dup     = 1'b0;
      live    = 1'b0;
      w_wr_ok = '0;
      w_ill   = '0;
      w_coll  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         dup = 1'b0;
         for (int j = 0; j < c; j++) begin
            if (wr_en[j] && wr_addr[j] == wr_addr[c])
               dup = 1'b1;
         end
         live       = wr_en[c] && (wr_addr[c] != '0);
         w_coll[c]  = live && dup;
         w_ill[c]   = live && (r_st[wr_addr[c]] != PR_PENDING);
         w_wr_ok[c] = live && !dup && (r_st[wr_addr[c]] == PR_PENDING);
      end
   end

   always_comb begin
      logic [CW-1:0]     ninc;
      logic [CW-1:0]     nrel;
      logic [CW-1:0]     up;
      logic [CW-1:0]     t;
      logic              gnt;
      logic              wr;
      logic [DATA_W-1:0] wd;
      ninc      = '0;
      nrel      = '0;
      up        = '0;
      t         = '0;
      gnt       = 1'b0;
      wr        = 1'b0;
      wd        = '0;
      w_of      = 1'b0;
      w_uf      = 1'b0;
      w_free_nx = '0;
      for (int i = 0; i < NP; i++) begin
         w_st_nx[i]   = r_st[i];
         w_cnt_nx[i]  = r_cnt[i];
         w_data_nx[i] = r_data[i];
      end
      for (int i = 1; i < NP; i++) begin
         ninc = '0;
         nrel = '0;
         gnt  = 1'b0;
         wr   = 1'b0;
         wd   = '0;
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (inc_en[c] && inc_pr[c] == PW'(i))
               ninc = ninc + CW'(1);
            if (rel_en[c] && rel_pr[c] == PW'(i))
               nrel = nrel + CW'(1);
            if (w_gnt[c] && w_gnt_pr[c] == PW'(i))
               gnt = 1'b1;
            if (w_wr_ok[c] && wr_addr[c] == PW'(i)) begin
               wr = 1'b1;
               wd = wr_data[c];
            end
         end
         if (r_st[i] == PR_FREE) begin
            if (nrel != '0)
               w_uf = 1'b1;
            if (gnt) begin
               w_st_nx[i]  = PR_PENDING;
               w_cnt_nx[i] = RC_W'(1);
            end
         end else begin
            if (wr) begin
               w_st_nx[i]   = PR_VALID;
               w_data_nx[i] = wd;
            end
            up = CW'(r_cnt[i]) + ninc;
            if (nrel > up) begin
               w_uf = 1'b1;
               t    = '0;
            end else begin
               t = up - nrel;
            end
            if (t > CW'(RC_MAX)) begin
               w_of        = 1'b1;
               w_cnt_nx[i] = RC_MAX;
            end else begin
               w_cnt_nx[i] = t[RC_W-1:0];
            end
            if (t == '0)
               w_st_nx[i] = PR_FREE;
         end
      end
      for (int i = 0; i < NP; i++) begin
         if (w_st_nx[i] == PR_FREE)
            w_free_nx = w_free_nx + FW'(1);
      end
   end

   always_comb begin
      logic [PW-1:0] a;
      a        = '0;
      rd_data  = '0;
      rd_valid = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int r = 0; r < NUM_RD; r++) begin
            a              = rd_addr[c][r];
            rd_data[c][r]  = r_data[a];
            rd_valid[c][r] = (r_st[a] == PR_VALID);
            if (BYPASS != 0) begin
               for (int w = NUM_CH - 1; w >= 0; w--) begin
                  if (w_wr_ok[w] && wr_addr[w] == a) begin
                     rd_data[c][r]  = wr_data[w];
                     rd_valid[c][r] = 1'b1;
                  end
               end
            end
            if (a == '0) begin
               rd_data[c][r]  = '0;
               rd_valid[c][r] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_err_set           = '0;
      w_err_set[ERR_OF]   = w_of;
      w_err_set[ERR_UF]   = w_uf;
      w_err_set[ERR_ILL]  = |w_ill;
      w_err_set[ERR_COLL] = |w_coll;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NP; i++) begin
            r_st[i]   <= (i < NUM_ARCH) ? PR_VALID : PR_FREE;
            r_cnt[i]  <= (i < NUM_ARCH) ? RC_W'(1) : '0;
            r_data[i] <= '0;
         end
         r_free <= FW'(NP - NUM_ARCH);
         r_err  <= '0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            r_st[i]   <= w_st_nx[i];
            r_cnt[i]  <= w_cnt_nx[i];
            r_data[i] <= w_data_nx[i];
         end
         r_free <= w_free_nx;
         r_err  <= r_err | w_err_set;
      end
   end

   assign free_count = r_free;
   assign err_flags  = r_err;

endmodule

// File: tb/tb_phy_regfile_rc.sv
// Randomized bench for phy_regfile_rc against a behavioural model.
// Directed scenarios pin allocation, bypass, ref counts and errors.
module tb_phy_regfile_rc;

   localparam int NP = 64;
   localparam int NA = 32;
   localparam int NC = 2;
   localparam int NR = 2;
   localparam int DW = 32;
   localparam int PW = 6;
   localparam int S_FREE = 0;
   localparam int S_PEND = 1;
   localparam int S_VAL  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NC-1:0]                 alloc_req;
   logic [NC-1:0]                 alloc_gnt;
   logic [NC-1:0][PW-1:0]         alloc_pr;
   logic [NC-1:0][NR-1:0][PW-1:0] rd_addr;
   logic [NC-1:0][NR-1:0][DW-1:0] rd_data;
   logic [NC-1:0][NR-1:0]         rd_valid;
   logic [NC-1:0]                 wr_en;
   logic [NC-1:0][PW-1:0]         wr_addr;
   logic [NC-1:0][DW-1:0]         wr_data;
   logic [NC-1:0]                 inc_en;
   logic [NC-1:0][PW-1:0]         inc_pr;
   logic [NC-1:0]                 rel_en;
   logic [NC-1:0][PW-1:0]         rel_pr;
   logic [PW:0]                   free_count;
   logic [3:0]                    err_flags;

   phy_regfile_rc #(
      .NUM_PHY_REGS (NP),
      .NUM_ARCH     (NA),
      .NUM_CH       (NC),
      .NUM_RD       (NR),
      .DATA_W       (DW),
      .RC_W         (4),
      .BYPASS       (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_req  (alloc_req),
      .alloc_gnt  (alloc_gnt),
      .alloc_pr   (alloc_pr),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .inc_en     (inc_en),
      .inc_pr     (inc_pr),
      .rel_en     (rel_en),
      .rel_pr     (rel_pr),
      .free_count (free_count),
      .err_flags  (err_flags)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Model: committed per-PR state, ref count and data.
   int             m_st  [NP];
   int             m_cnt [NP];
   logic [DW-1:0]  m_data[NP];
   logic [3:0]     m_err;
   int             n_st  [NP];
   int             n_cnt [NP];
   logic [DW-1:0]  n_data[NP];
   logic [3:0]     n_err;
   bit             have_nx = 0;

   task automatic m_reset();
      for (int i = 0; i < NP; i++) begin
         m_st[i]   = (i < NA) ? S_VAL : S_FREE;
         m_cnt[i]  = (i < NA) ? 1 : 0;
         m_data[i] = '0;
      end
      m_err = '0;
   endtask

   function automatic int m_free_cnt();
      int n = 0;
      for (int i = 0; i < NP; i++)
         if (m_st[i] == S_FREE) n++;
      return n;
   endfunction

   always @(negedge clk) begin : cmp
      int fq[$];
      int seen[$];
      int gpr[NC];
      int acc[NC];
      int k, a, t, ninc, nrel;
      bit ev, e_of, e_uf, e_ill, e_coll, g, dup;
      logic [DW-1:0] ed;
      if (!rst_n) begin
         m_reset();
         have_nx = 0;
         for (int c = 0; c < NC; c++)
            chk($sformatf("rst_gnt%0d", c), 64'(alloc_gnt[c]), 64'd0);
         chk("rst_free", 64'(free_count), 64'd32);
         chk("rst_err", 64'(err_flags), 64'd0);
         for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) begin
               a = int'(rd_addr[c][r]);
               chk($sformatf("rst_rv%0d_%0d", c, r), 64'(rd_valid[c][r]),
                   64'(a < NA));
               if (a < NA)
                  chk($sformatf("rst_rd%0d_%0d", c, r), 64'(rd_data[c][r]),
                      64'd0);
            end
      end else begin
         fq.delete();
         seen.delete();
         for (int i = 1; i < NP; i++)
            if (m_st[i] == S_FREE) fq.push_back(i);
         k = 0;
         for (int c = 0; c < NC; c++) begin
            gpr[c] = -1;
            if (alloc_req[c] && k < fq.size()) begin
               gpr[c] = fq[k];
               k++;
            end
            chk($sformatf("gnt%0d", c), 64'(alloc_gnt[c]), 64'(gpr[c] >= 0));
            if (gpr[c] >= 0)
               chk($sformatf("gpr%0d", c), 64'(alloc_pr[c]), 64'(gpr[c]));
         end
         e_ill  = 0;
         e_coll = 0;
         for (int c = 0; c < NC; c++) begin
            acc[c] = 0;
            a = int'(wr_addr[c]);
            if (wr_en[c] && a != 0) begin
               dup = 0;
               foreach (seen[j]) if (seen[j] == a) dup = 1;
               seen.push_back(a);
               if (dup) e_coll = 1;
               if (m_st[a] != S_PEND) e_ill = 1;
               else if (!dup) acc[c] = 1;
            end
         end
         for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) begin
               a = int'(rd_addr[c][r]);
               ev = (m_st[a] == S_VAL);
               ed = m_data[a];
               for (int w = NC - 1; w >= 0; w--)
                  if (acc[w] != 0 && int'(wr_addr[w]) == a) begin
                     ev = 1;
                     ed = wr_data[w];
                  end
               if (a == 0) begin
                  ev = 1;
                  ed = '0;
               end
               chk($sformatf("rv%0d_%0d", c, r), 64'(rd_valid[c][r]), 64'(ev));
               if (ev)
                  chk($sformatf("rd%0d_%0d", c, r), 64'(rd_data[c][r]),
                      64'(ed));
            end
         chk("free", 64'(free_count), 64'(m_free_cnt()));
         chk("err", 64'(err_flags), 64'(m_err));
         e_of = 0;
         e_uf = 0;
         for (int i = 0; i < NP; i++) begin
            n_st[i]   = m_st[i];
            n_cnt[i]  = m_cnt[i];
            n_data[i] = m_data[i];
         end
         for (int i = 1; i < NP; i++) begin
            ninc = 0;
            nrel = 0;
            g    = 0;
            for (int c = 0; c < NC; c++) begin
               if (inc_en[c] && int'(inc_pr[c]) == i) ninc++;
               if (rel_en[c] && int'(rel_pr[c]) == i) nrel++;
               if (gpr[c] == i) g = 1;
            end
            if (m_st[i] == S_FREE) begin
               if (nrel > 0) e_uf = 1;
               if (g) begin
                  n_st[i]  = S_PEND;
                  n_cnt[i] = 1;
               end
            end else begin
               for (int c = 0; c < NC; c++)
                  if (acc[c] != 0 && int'(wr_addr[c]) == i) begin
                     n_data[i] = wr_data[c];
                     n_st[i]   = S_VAL;
                  end
               t = m_cnt[i] + ninc - nrel;
               if (t < 0) begin e_uf = 1; t = 0; end
               if (t > 15) begin e_of = 1; t = 15; end
               n_cnt[i] = t;
               if (t == 0) n_st[i] = S_FREE;
            end
         end
         n_err = m_err | {e_of, e_uf, e_ill, e_coll};
         have_nx = 1;
      end
   end

   always @(posedge clk) begin
      if (rst_n && have_nx) begin
         for (int i = 0; i < NP; i++) begin
            m_st[i]   = n_st[i];
            m_cnt[i]  = n_cnt[i];
            m_data[i] = n_data[i];
         end
         m_err = n_err;
      end
      have_nx = 0;
   end

   task automatic idle();
      alloc_req = '0;
      rd_addr   = '0;
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      inc_en    = '0;
      inc_pr    = '0;
      rel_en    = '0;
      rel_pr    = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick_live(input int want);
      int q[$];
      for (int i = 1; i < NP; i++)
         if (m_st[i] == want || (want < 0 && m_st[i] != S_FREE))
            q.push_back(i);
      if (q.size() == 0) return int'($urandom_range(0, NP - 1));
      return q[$urandom_range(0, q.size() - 1)];
   endfunction

   task automatic rand_cycle();
      idle();
      for (int c = 0; c < NC; c++) begin
         alloc_req[c] = 1'($urandom_range(0, 1));
         wr_en[c]     = 1'($urandom_range(0, 1));
         wr_addr[c]   = ($urandom_range(0, 2) != 0) ? PW'(pick_live(S_PEND))
                                                    : PW'($urandom_range(0, NP - 1));
         wr_data[c]   = $urandom;
         inc_en[c]    = ($urandom_range(0, 3) == 0);
         inc_pr[c]    = PW'(pick_live(-1));
         rel_en[c]    = ($urandom_range(0, 4) < 2);
         rel_pr[c]    = ($urandom_range(0, 9) < 7) ? PW'(pick_live(-1))
                                                   : PW'($urandom_range(0, NP - 1));
      end
      if ($urandom_range(0, 9) == 0) wr_addr[1] = wr_addr[0];
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            rd_addr[c][r] = ($urandom_range(0, 1) != 0)
                            ? wr_addr[$urandom_range(0, NC - 1)]
                            : PW'($urandom_range(0, NP - 1));
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;

      alloc_req = 2'b11;
      @(negedge clk);
      chk("a32_gnt0", 64'(alloc_gnt[0]), 64'd1);
      chk("a32_pr0", 64'(alloc_pr[0]), 64'd32);
      chk("a33_gnt1", 64'(alloc_gnt[1]), 64'd1);
      chk("a33_pr1", 64'(alloc_pr[1]), 64'd33);
      tick();
      alloc_req     = '0;
      rd_addr[0][0] = PW'(32);
      @(negedge clk);
      chk("free30", 64'(free_count), 64'd30);
      chk("pend_inval", 64'(rd_valid[0][0]), 64'd0);

      tick();
      wr_en[0]      = 1'b1;
      wr_addr[0]    = PW'(32);
      wr_data[0]    = 32'hDEADBEEF;
      rd_addr[1][1] = PW'(32);
      @(negedge clk);
      chk("byp_v", 64'(rd_valid[1][1]), 64'd1);
      chk("byp_d", 64'(rd_data[1][1]), 64'hDEADBEEF);
      tick();
      wr_en = '0;
      @(negedge clk);
      chk("stored_d", 64'(rd_data[0][0]), 64'hDEADBEEF);

      tick();
      inc_en[0] = 1'b1;
      inc_pr[0] = PW'(32);
      tick();
      inc_en    = '0;
      inc_en[1] = 1'b1;
      inc_pr[1] = PW'(32);
      tick();
      inc_en    = '0;
      rel_en[0] = 1'b1;
      rel_pr[0] = PW'(32);
      tick();
      tick();
      @(negedge clk);
      chk("rc_live", 64'(rd_valid[0][0]), 64'd1);
      tick();
      rel_en    = '0;
      alloc_req = 2'b01;
      @(negedge clk);
      chk("rc_freed", 64'(rd_valid[0][0]), 64'd0);
      chk("free31", 64'(free_count), 64'd31);
      chk("regrant32", 64'(alloc_pr[0]), 64'd32);

      tick();
      alloc_req = 2'b11;
      repeat (3) tick();
      @(negedge clk);
      chk("a40", 64'(alloc_pr[0]), 64'd40);
      tick();
      alloc_req     = '0;
      wr_en         = 2'b11;
      wr_addr[0]    = PW'(40);
      wr_addr[1]    = PW'(40);
      wr_data[0]    = 32'h11111111;
      wr_data[1]    = 32'h22222222;
      rd_addr[0][0] = PW'(40);
      tick();
      wr_en = '0;
      @(negedge clk);
      chk("coll_d", 64'(rd_data[0][0]), 64'h11111111);
      chk("coll_f", 64'(err_flags[0]), 64'd1);
      chk("ill_0", 64'(err_flags[1]), 64'd0);
      tick();
      wr_en[0]   = 1'b1;
      wr_data[0] = 32'h33333333;
      tick();
      wr_en = '0;
      @(negedge clk);
      chk("ill_f", 64'(err_flags[1]), 64'd1);
      chk("ill_d", 64'(rd_data[0][0]), 64'h11111111);

      tick();
      inc_en = 2'b11;
      inc_pr = {PW'(40), PW'(40)};
      repeat (7) tick();
      inc_en = 2'b01;
      tick();
      inc_en = '0;
      @(negedge clk);
      chk("of_f", 64'(err_flags[3]), 64'd1);
      tick();
      rel_en = 2'b11;
      rel_pr = {PW'(40), PW'(40)};
      repeat (7) tick();
      rel_en = '0;
      @(negedge clk);
      chk("sat15_live", 64'(rd_valid[0][0]), 64'd1);
      tick();
      rel_en = 2'b01;
      tick();
      rel_en = '0;
      @(negedge clk);
      chk("sat15_free", 64'(rd_valid[0][0]), 64'd0);
      chk("uf_0", 64'(err_flags[2]), 64'd0);
      tick();
      rel_en[1]     = 1'b1;
      rel_pr[1]     = PW'(50);
      rd_addr[0][1] = PW'(50);
      tick();
      rel_en = '0;
      @(negedge clk);
      chk("uf_f", 64'(err_flags[2]), 64'd1);
      chk("uf_free23", 64'(free_count), 64'd23);
      chk("uf_inval", 64'(rd_valid[0][1]), 64'd0);

      repeat (3000) begin
         tick();
         rand_cycle();
      end

      tick();
      idle();
      alloc_req     = 2'b11;
      wr_en         = 2'b11;
      wr_data       = {32'hAAAA5555, 32'h12345678};
      inc_en        = 2'b11;
      rd_addr[1][0] = PW'(40);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_gnt", 64'(alloc_gnt), 64'd0);
      chk("mid_pr0v", 64'(rd_valid[0][0]), 64'd1);
      chk("mid_pr0d", 64'(rd_data[0][0]), 64'd0);
      tick();
      idle();
      rd_addr[0][1] = PW'(31);
      rd_addr[1][0] = PW'(32);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_free", 64'(free_count), 64'd32);
      chk("post_err", 64'(err_flags), 64'd0);
      chk("post_r31v", 64'(rd_valid[0][1]), 64'd1);
      chk("post_r31d", 64'(rd_data[0][1]), 64'd0);
      chk("post_r32v", 64'(rd_valid[1][0]), 64'd0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
